// File: rtl/lipsi_pkg.sv
// Shared definitions for the Lipsi memory arbiter: default widths, the
// host-wait bound and the arbiter state encoding.
package lipsi_pkg;

  localparam int DEF_ADDR_W        = 8;
  localparam int DEF_DATA_W        = 8;
  localparam int DEF_MAX_HOST_WAIT = 4;

  typedef enum logic {
    ARB_RUN  = 1'b0,
    ARB_HALT = 1'b1
  } arb_state_t;

endpackage

// File: rtl/lipsi_wait_ctr.sv
// Saturating bounded-wait counter: counts cycles a pending host request has
// lost to the core, and flags when the bound is reached.
module lipsi_wait_ctr #(
  parameter int MAX_HOST_WAIT = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clr,
  input  logic       inc,
  output logic [3:0] cnt,
  output logic       sat
);

  localparam logic [3:0] MAX_CNT = 4'(MAX_HOST_WAIT);

  assign sat = (cnt == MAX_CNT);

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= 4'd0;
    end else if (clr) begin
      cnt <= 4'd0;
    end else if (inc && !sat) begin
      cnt <= cnt + 4'd1;
    end
  end

endmodule

// File: rtl/lipsi_mem_arbiter.sv
// Single-port memory arbiter between the Lipsi core and an external host port,
// with core priority, bounded host wait and an exclusive-host HALT mode.
module lipsi_mem_arbiter
  import lipsi_pkg::*;
#(
  parameter int ADDR_W        = DEF_ADDR_W,
  parameter int DATA_W        = DEF_DATA_W,
  parameter int MAX_HOST_WAIT = DEF_MAX_HOST_WAIT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              core_req,
  input  logic              core_we,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wdata,
  output logic [DATA_W-1:0] core_rdata,
  output logic              core_stall,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic [DATA_W-1:0] host_rdata,
  output logic              host_ack,
  input  logic              host_halt,
  output logic              halted,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata
);

  arb_state_t state_q, state_d;
  logic       grant_host, grant_core;
  logic       wait_sat;
  logic [3:0] wait_cnt;
  logic       ack_p1;

  lipsi_wait_ctr #(
    .MAX_HOST_WAIT(MAX_HOST_WAIT)
  ) u_wait_ctr (
    .clk  (clk),
    .reset(reset),
    .clr  (grant_host || !host_req),
    .inc  (host_req && core_req),
    .cnt  (wait_cnt),
    .sat  (wait_sat)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ARB_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ARB_RUN:  if (host_halt)  state_d = ARB_HALT;
      ARB_HALT: if (!host_halt) state_d = ARB_RUN;
      default:  state_d = ARB_RUN;
    endcase
  end

  // Grants are masked during reset so no access (and no later ack) can start.
  always_comb begin
    grant_host = !reset && host_req &&
                 (state_q == ARB_HALT || !core_req || wait_sat);
    grant_core = !reset && core_req && !grant_host && (state_q == ARB_RUN);
  end

  always_comb begin
    mem_addr  = core_addr;
    mem_wdata = core_wdata;
    mem_we    = 1'b0;
    if (grant_host) begin
      mem_addr  = host_addr;
      mem_wdata = host_wdata;
      mem_we    = host_we;
    end else if (grant_core) begin
      mem_we    = core_we;
    end
  end

  assign core_stall = !reset && ((state_q == ARB_HALT) || (core_req && grant_host));
  assign halted     = (state_q == ARB_HALT);

  // Ack stage: memory read data for the host grant arrives with the ack.
  always_ff @(posedge clk) begin
    if (reset) begin
      ack_p1 <= 1'b0;
    end else begin
      ack_p1 <= grant_host;
    end
  end

  assign host_ack   = ack_p1;
  assign host_rdata = mem_rdata;
  assign core_rdata = mem_rdata;

endmodule

// File: tb/tb_lipsi_mem_arbiter.sv
// Self-checking bench for lipsi_mem_arbiter: directed scenarios followed by
// randomized traffic against a behavioural arbitration and memory model.
module tb_lipsi_mem_arbiter;

  localparam int MAXW = 4;

  logic       clk;
  logic       reset;
  logic       core_req, core_we;
  logic [7:0] core_addr, core_wdata, core_rdata;
  logic       core_stall;
  logic       host_req, host_we;
  logic [7:0] host_addr, host_wdata, host_rdata;
  logic       host_ack, host_halt, halted;
  logic [7:0] mem_addr, mem_wdata, mem_rdata;
  logic       mem_we;

  lipsi_mem_arbiter #(
    .ADDR_W(8), .DATA_W(8), .MAX_HOST_WAIT(MAXW)
  ) dut (
    .clk(clk), .reset(reset),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr),
    .core_wdata(core_wdata), .core_rdata(core_rdata), .core_stall(core_stall),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_rdata(host_rdata), .host_ack(host_ack),
    .host_halt(host_halt), .halted(halted),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_rdata(mem_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [7:0] init_val(input int i);
    return (i == 'h10) ? 8'h5A : 8'((i * 7 + 3) & 'hFF);
  endfunction

  // Memory macro: synchronous read, 1-cycle latency, contents set on first edge.
  logic [7:0] mem [256];
  logic       init_done = 1'b0;
  always @(posedge clk) begin
    if (!init_done) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_val(i);
      init_done <= 1'b1;
    end else begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      mem_rdata <= mem[mem_addr];
    end
  end

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model state
  logic [7:0] refmem [256];
  logic       m_known, m_halted, m_ack;
  int         m_lost;
  logic       m_core_vld, m_host_chk;
  logic [7:0] m_core_exp, m_host_exp;
  logic       last_gh, last_gc, last_stall;

  task automatic tick();
    logic e_gh, e_gc, e_stall, e_we;
    logic [7:0] e_addr, e_wd;
    #1;
    e_gh    = !reset && host_req && (m_halted || !core_req || m_lost >= MAXW);
    e_gc    = !reset && core_req && !e_gh && !m_halted;
    e_stall = !reset && (m_halted || (core_req && e_gh));
    e_we    = e_gh ? host_we : (e_gc && core_we);
    e_addr  = e_gh ? host_addr : core_addr;
    e_wd    = e_gh ? host_wdata : core_wdata;
    chk("core_stall", core_stall, e_stall);
    chk("mem_we", mem_we, e_we);
    chk("mem_addr", mem_addr, e_addr);
    chk("mem_wdata", mem_wdata, e_wd);
    if (m_known) begin
      chk("halted", halted, m_halted);
      chk("host_ack", host_ack, m_ack);
    end
    if (m_core_vld) chk("core_rdata", core_rdata, m_core_exp);
    if (m_host_chk) chk("host_rdata", host_rdata, m_host_exp);
    last_gh = e_gh; last_gc = e_gc; last_stall = e_stall;
    @(posedge clk);
    if (reset) begin
      m_known = 1'b1; m_halted = 1'b0; m_ack = 1'b0; m_lost = 0;
      m_core_vld = 1'b0; m_host_chk = 1'b0;
    end else begin
      m_core_vld = e_gc && !core_we;
      m_core_exp = refmem[core_addr];
      m_host_chk = e_gh && !host_we;
      m_host_exp = refmem[host_addr];
      if (e_we) refmem[e_addr] = e_wd;
      m_ack    = e_gh;
      m_halted = host_halt;
      if (e_gh || !host_req) m_lost = 0;
      else if (core_req && m_lost < MAXW) m_lost++;
    end
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    core_req = 0; core_we = 0; core_addr = 0; core_wdata = 0;
    host_req = 0; host_we = 0; host_addr = 0; host_wdata = 0;
    host_halt = 0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) refmem[i] = init_val(i);
    m_known = 0; m_halted = 0; m_ack = 0; m_lost = 0;
    m_core_vld = 0; m_host_chk = 0; m_core_exp = 0; m_host_exp = 0;
    last_gh = 0; last_gc = 0; last_stall = 0;

    // Reset with every request asserted
    reset = 1; core_req = 1; core_we = 1; core_addr = 8'h44; core_wdata = 8'h11;
    host_req = 1; host_we = 1; host_addr = 8'h45; host_wdata = 8'h22; host_halt = 1;
    tick(); tick();
    chk("rst_halted", halted, 1'b0);
    chk("rst_ack", host_ack, 1'b0);
    reset = 0; idle_inputs();
    tick();
    chk("post_rst_halted", halted, 1'b0);

    // Core read of preloaded location
    core_req = 1; core_addr = 8'h10;
    tick();
    chk("core_rd_stall", last_stall, 1'b0);
    core_req = 0;
    chk("core_rd_data", core_rdata, 8'h5A);
    tick();

    // Host write with idle core
    host_req = 1; host_we = 1; host_addr = 8'h20; host_wdata = 8'hA5;
    tick();
    chk("hw_ack_hi", host_ack, 1'b1);
    host_req = 0; host_we = 0;
    tick();
    chk("hw_ack_lo", host_ack, 1'b0);

    // Bounded wait under continuous core traffic
    core_req = 1; core_we = 0; core_addr = 8'h30;
    host_req = 1; host_we = 0; host_addr = 8'h10;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (i <= 4) begin
        chk("bw_grant_host", last_gh, (i == 4));
        chk("bw_stall", last_stall, (i == 4));
      end
      if (last_gh) host_req = 0;
      if (i == 4) chk("bw_ack", host_ack, 1'b1);
    end

    // HALT mode: host exclusive, core stalled
    host_halt = 1;
    tick();
    chk("halt_enter", halted, 1'b1);
    tick();
    chk("halt_stall", last_stall, 1'b1);
    host_req = 1; host_we = 0; host_addr = 8'h20;
    tick();
    host_req = 0;
    chk("halt_rd_ack", host_ack, 1'b1);
    chk("halt_rd_data", host_rdata, 8'hA5);
    host_halt = 0;
    tick();
    chk("halt_exit", halted, 1'b0);
    tick();
    chk("resume_stall", last_stall, 1'b0);
    chk("resume_grant", last_gc, 1'b1);

    // Reset while in HALT with a host write pending
    host_halt = 1; core_req = 0;
    tick();
    reset = 1; host_req = 1; host_we = 1; host_addr = 8'h40; host_wdata = 8'hEE;
    tick();
    reset = 0; host_req = 0; host_we = 0; host_halt = 0;
    chk("rst_halt_halted", halted, 1'b0);
    chk("rst_halt_ack", host_ack, 1'b0);
    chk("rst_halt_nowrite", mem[8'h40], init_val('h40));
    tick();
    chk("rst_halt_ack2", host_ack, 1'b0);

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      reset = ($urandom_range(0, 99) == 0);
      if (!(core_req && last_stall)) begin
        core_req   = ($urandom_range(0, 9) < 7);
        core_we    = $urandom_range(0, 1);
        core_addr  = 8'($urandom_range(0, 15));
        core_wdata = 8'($urandom);
      end
      if (!(host_req && !last_gh)) begin
        host_req   = ($urandom_range(0, 9) < 4);
        host_we    = $urandom_range(0, 1);
        host_addr  = 8'($urandom_range(0, 15));
        host_wdata = 8'($urandom);
      end
      if ($urandom_range(0, 19) == 0) host_halt = ~host_halt;
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
